motor_duty_ramp: RTL
====================

Name: motor_duty_ramp

Overview:
Slew-rate limiter and direction sequencer that sits directly upstream of the PWM generator for each drive motor. It accepts target duty/direction commands from the motion controller. It produces a registered duty word, which feeds the PWM `number` input, and a direction bit for the H-bridge. Duty moves toward the target by a fixed step per ramp tick. A direction change always ramps to zero, dwells, then reverses, so the H-bridge is never reversed under load.

Parameters:
LENGTH, 10, width of duty word; must match the PWM width.
PRESCALE, 1000, clock cycles per ramp tick; must be >= 2.
STEP, 4, duty change per ramp tick; 1 <= STEP < 2^LENGTH.
DWELL_TICKS, 8, ramp ticks spent at duty 0 before a direction flip; must be >= 1.
WDT_TICKS, 256, ramp ticks without a command before the watchdog fires. Used only with RAMP_WATCHDOG_EN.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command may be accepted; combinational, equal to !estop
cmd_duty  in  LENGTH  target duty
cmd_dir  in  1  target direction (0 = forward)
estop  in  1  synchronous emergency stop, level-sensitive
duty  out  LENGTH  registered duty to PWM
dir  out  1  registered H-bridge direction
at_target  out  1  duty == tgt_duty && dir == tgt_dir && state == RUN
busy  out  1  equal to !at_target
wdt_expired  out  1  present only with RAMP_WATCHDOG_EN

Behaviour:
- Reset (rst_n low at posedge) sets the following values:
  - duty=0, dir=0, tgt_duty=0, tgt_dir=0.
  - Prescaler = 0, dwell count = 0, state = RUN.
  - Resulting outputs: at_target=1, busy=0, wdt_expired=0.
- Reset mid-ramp or mid-dwell abandons the operation with no residual state.
- Prescaler counts 0..PRESCALE-1 and wraps. `tick` is asserted for one cycle when the count equals PRESCALE-1.
- Command handshake:
  - A command is accepted on a posedge where cmd_valid && cmd_ready.
  - tgt_duty/tgt_dir are overwritten on that edge.
  - There is no queue; the last accepted command wins.
- If accept and tick coincide, the tick acts on the old target. The new target takes effect from the next tick.
- State RUN, on tick, where "same dir" means tgt_dir == dir:
  - Same dir, duty < tgt: duty <= min(duty+STEP, tgt). Compute in LENGTH+1 bits; the result never wraps.
  - Same dir, duty > tgt: duty <= max(duty-STEP, tgt). The result never underflows.
  - Same dir, duty == tgt: hold.
  - tgt_dir != dir, duty > 0: duty <= (duty > STEP) ? duty-STEP : 0.
  - tgt_dir != dir, duty == 0: go to DWELL and clear the dwell count.
- State DWELL, on tick:
  - duty stays 0 and dwell count increments.
  - When the count reaches DWELL_TICKS-1: dir <= tgt_dir, then go to RUN.
  - The dwell always completes, even if the target direction reverts meanwhile.
  - New commands are accepted during DWELL; only the final tgt_dir is applied.
- estop high at a posedge (priority below reset, above everything else):
  - duty <= 0, tgt_duty <= 0, state <= RUN, prescaler <= 0.
  - dir and tgt_dir are unchanged.
  - cmd_ready stays low while estop is high.
  - After release, duty remains 0 until a new command is accepted.
- No combinational path exists from cmd_* to duty or dir. Duty changes at most once per PRESCALE cycles.

Optional Feature:
Macro RAMP_WATCHDOG_EN.
- Defined:
  - A tick counter clears on every accepted command and saturates at WDT_TICKS.
  - When the counter reaches WDT_TICKS: tgt_duty <= 0 (tgt_dir kept) and wdt_expired <= 1, sticky.
  - Duty then ramps down normally.
  - The next accepted command clears wdt_expired and the counter.
  - Reset and estop also clear both.
- Undefined: the counter and the wdt_expired port do not exist, and the target is held indefinitely.

Test Plan:
All scenarios use LENGTH=10, PRESCALE=4, STEP=4, DWELL_TICKS=2, WDT_TICKS=5.
1. Reset held 3 cycles, then released -> duty=0, dir=0, at_target=1, busy=0, cmd_ready=1.
2. Command duty=10, dir=0 -> duty goes 4, 8, 10 on three successive ticks (4 clocks apart); at_target=1 after the third tick; duty holds thereafter.
3. From duty=10 dir=0, command duty=6 dir=1 -> duty 6, 2, 0; two dwell ticks at 0; dir flips to 1; duty 4, 6; at_target=1.
4. estop asserted while duty=8 -> duty=0 at the next posedge; cmd_valid with duty=500 is not accepted while estop is high; duty=0 after release.
5. Boundaries:
   - duty=1020 with target 1023 -> one tick gives 1023 (no wrap).
   - duty=2 with target 0 -> one tick gives 0 (no underflow).
   - Command accepted on the tick cycle -> the old target is used for that tick.
6. RAMP_WATCHDOG_EN, steady duty=20 with no further commands -> after 5 ticks wdt_expired=1 and duty ramps 16, 12, ..., 0. A new command then clears wdt_expired.

Source files
------------

// File: rtl/motor_duty_ramp.sv
// Slew-rate limited duty/direction sequencer feeding a PWM generator and H-bridge.
// Optional command watchdog enabled by defining RAMP_WATCHDOG_EN.
module motor_duty_ramp #(
  parameter int LENGTH      = 10,
  parameter int PRESCALE    = 1000,
  parameter int STEP        = 4,
  parameter int DWELL_TICKS = 8,
  parameter int WDT_TICKS   = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LENGTH-1:0] cmd_duty,
  input  logic              cmd_dir,
  input  logic              estop,
  output logic [LENGTH-1:0] duty,
  output logic              dir,
  output logic              at_target,
  output logic              busy
`ifdef RAMP_WATCHDOG_EN
  ,
  output logic              wdt_expired
`endif
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam logic [PW-1:0]     PRESCALE_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0]     DWELL_LAST    = DW'(DWELL_TICKS - 1);
  localparam logic [LENGTH-1:0] STEP_N        = LENGTH'(STEP);
  localparam logic [LENGTH:0]   STEP_W        = (LENGTH + 1)'(STEP);

  if (PRESCALE < 2 || STEP < 1 || DWELL_TICKS < 1 || WDT_TICKS < 1) begin : g_bad_params
    $error("motor_duty_ramp: illegal parameter value");
  end

  typedef enum logic {RUN, DWELL} state_t;

  state_t            state;
  logic [PW-1:0]     presc;
  logic [DW-1:0]     dwell_cnt;
  logic [LENGTH-1:0] tgt_duty;
  logic              tgt_dir;
  logic              tick;
  logic              accept;
  logic [LENGTH:0]   duty_up;
  logic [LENGTH-1:0] over_tgt;
  logic [LENGTH-1:0] next_duty;

  assign tick      = (presc == PRESCALE_LAST);
  assign cmd_ready = !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign duty_up   = {1'b0, duty} + STEP_W;
  assign over_tgt  = duty - tgt_duty;
  assign at_target = (duty == tgt_duty) && (dir == tgt_dir) && (state == RUN);
  assign busy      = !at_target;

  // One ramp step toward the target; a pending reversal always heads for zero first.
  always_comb begin
    next_duty = duty;
    if (tgt_dir != dir)
      next_duty = (duty > STEP_N) ? duty - STEP_N : '0;
    else if (duty < tgt_duty)
      next_duty = (duty_up > {1'b0, tgt_duty}) ? tgt_duty : duty_up[LENGTH-1:0];
    else if (duty > tgt_duty)
      next_duty = (over_tgt > STEP_N) ? duty - STEP_N : tgt_duty;
  end

`ifdef RAMP_WATCHDOG_EN
  localparam int WW = $clog2(WDT_TICKS + 1);
  localparam logic [WW-1:0] WDT_MAX  = WW'(WDT_TICKS);
  localparam logic [WW-1:0] WDT_FIRE = WW'(WDT_TICKS - 1);
  logic [WW-1:0] wdt_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty      <= '0;
      dir       <= 1'b0;
      tgt_duty  <= '0;
      tgt_dir   <= 1'b0;
      presc     <= '0;
      dwell_cnt <= '0;
      state     <= RUN;
`ifdef RAMP_WATCHDOG_EN
      wdt_cnt     <= '0;
      wdt_expired <= 1'b0;
`endif
    end else if (estop) begin
      duty     <= '0;
      tgt_duty <= '0;
      state    <= RUN;
      presc    <= '0;
`ifdef RAMP_WATCHDOG_EN
      wdt_cnt     <= '0;
      wdt_expired <= 1'b0;
`endif
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (accept) begin
        tgt_duty <= cmd_duty;
        tgt_dir  <= cmd_dir;
      end
      // The tick uses the target registered before this edge, so a coincident command waits.
      if (tick) begin
        case (state)
          RUN: begin
            if (tgt_dir != dir && duty == '0) begin
              state     <= DWELL;
              dwell_cnt <= '0;
            end else begin
              duty <= next_duty;
            end
          end
          DWELL: begin
            if (dwell_cnt == DWELL_LAST) begin
              dir   <= tgt_dir;
              state <= RUN;
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          default: state <= RUN;
        endcase
      end
`ifdef RAMP_WATCHDOG_EN
      if (accept) begin
        wdt_cnt     <= '0;
        wdt_expired <= 1'b0;
      end else if (tick && wdt_cnt != WDT_MAX) begin
        wdt_cnt <= wdt_cnt + 1'b1;
        if (wdt_cnt == WDT_FIRE) begin
          tgt_duty    <= '0;
          wdt_expired <= 1'b1;
        end
      end
`endif
    end
  end

endmodule
